vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Sole owner of the single-port frame-buffer RAM in the VGA renderer.
//  Shares the RAM between the scanout path and the UART pixel writer.
//  Scanout: prefetches pixels in raster order into an internal show-ahead FIFO that the VGA output stage pops once per active pixel.
//  Writer: has a valid/ready handshake and receives every RAM slot that scanout does not need.
// PARAMETERS
//  ADDR_W    15     frame-buffer word address width
//  DATA_W    16     pixel width (RGB565, matches V_R/V_G/V_B 5/6/5)
//  FB_WORDS  19200  pixels per frame; scan address runs 0..FB_WORDS-1
//  DEPTH     16     prefetch FIFO entries (power of 2)
//  LOW_WM    4      below this level, scanout has absolute priority
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  frame_start  in   1       1-cycle pulse from VGA timing (vsync start)
//  pix_pop      in   1       VGA output stage consumes pix_data
//  pix_data     out  DATA_W  FIFO head (show-ahead); 0 when empty
//  pix_valid    out  1       FIFO not empty
//  underrun     out  1       sticky: pop seen while empty this frame
//  wr_valid     in   1       writer request
//  wr_ready     out  1       write slot granted this cycle
//  wr_addr      in   ADDR_W  write address
//  wr_data      in   DATA_W  write pixel
//  ram_en       out  1       RAM access this cycle
//  ram_we       out  1       1 = write, 0 = read
//  ram_addr     out  ADDR_W  RAM address
//  ram_wdata    out  DATA_W  RAM write data
//  ram_rdata    in   DATA_W  RAM read data, valid 1 cycle after read
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - FIFO empty, scan_addr=0, inflight=0, underrun=0, last_grant=W.
//   - frame_done=1, so no scanout before the first frame_start.
//   - All outputs 0.
//  level = fifo_count + inflight, where inflight is 0 or 1 (RAM read latency is fixed at 1).
//  rd_elig = !frame_done && level < DEPTH;  wr_elig = wr_valid.
//  Grant (combinational, one RAM op per cycle):
//   - Only one eligible: it wins.
//   - Both eligible and level < LOW_WM: read wins.
//   - Both eligible and level >= LOW_WM: alternate, opposite of last_grant.
//   - frame_start cycle: no read is granted; a write may still be granted.
//  wr_ready = write granted. The transfer occurs on wr_valid && wr_ready.
//   - ram_we=1; ram_addr/ram_wdata = wr_addr/wr_data in the same cycle.
//   - wr_ready may depend on wr_valid. The writer must hold its address and data until the transfer.
//  Read grant:
//   - ram_addr = scan_addr; inflight set.
//   - scan_addr increments. On scan_addr == FB_WORDS-1 it wraps to 0 and frame_done is set.
//   - Next cycle, ram_rdata is pushed into the FIFO.
//  last_grant updates only on cycles where both requesters were eligible.
//  FIFO push and pop in the same cycle: count unchanged.
//  Pop while empty:
//   - Ignored; underrun set to 1.
//   - pix_data stays 0 (black).
//  frame_start:
//   - Flushes the FIFO.
//   - Drops the returning inflight data: that cycle's push is suppressed.
//   - scan_addr=0, frame_done=0, underrun=0.
//   - A same-cycle pop is ignored and is not counted as an underrun.
//   - A mid-frame frame_start restarts the scan cleanly.
//  Simultaneous frame_start and write: the write proceeds normally.
//  Unused RAM cycles: ram_en=0, ram_we=0, ram_addr/ram_wdata=0.
// TESTING
//  Test RAM: 1-cycle-latency model, mem[i]=i. Run with FB_WORDS=64, DEPTH=16, LOW_WM=4.
//  1 Reset, then wr_valid with addr 0x0010, data 0xF800:
//    -> wr_ready=1, ram_we=1, ram_addr=0x0010 in the same cycle.
//    -> pix_valid=0, no reads.
//  2 frame_start, no pops, no writes:
//    -> reads of addr 0..15 on 16 consecutive cycles.
//    -> Then ram_en=0; pix_valid=1, pix_data=0.
//  3 FIFO level >= 4 with wr_valid held high and one pop per cycle:
//    -> Grants alternate R,W,R,W.
//    -> Drain the level to 3 -> reads only until the level reaches 4.
//  4 pix_pop on the cycle after frame_start (FIFO empty):
//    -> underrun=1, pix_data=0.
//    -> Next frame_start clears underrun.
//  5 Pop all 64 pixels:
//    -> Data 0..63 in order; no read issued after addr 63.
//    -> Writes are granted every cycle afterwards.
//  6 frame_start while a read is inflight at addr 20:
//    -> Stale data dropped; next cycle pix_valid=0.
//    -> Next read addr 0. rst_n low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: raster-order scanout prefetch into a show-ahead FIFO,
// with every spare RAM slot handed to the pixel writer.
module vga_fb_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int FB_WORDS = 19200,
  parameter int DEPTH    = 16,
  parameter int LOW_WM   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underrun,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]     LOW_WM_C  = CW'(LOW_WM);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  logic [DATA_W-1:0] fifo_mem [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
  logic              inflight_q, inflight_d;
  logic              frame_done_q, frame_done_d;
  logic              underrun_q, underrun_d;
  logic              last_rd_q, last_rd_d;

  logic [CW-1:0]     level;
  logic              rd_elig;
  logic              grant_rd;
  logic              grant_wr;
  logic              push;
  logic              pop;

  // Grants are qualified by rst_n so every output is 0 while reset is held.
  always_comb begin
    level    = count_q + CW'(inflight_q);
    rd_elig  = !frame_done_q && (level < DEPTH_C) && !frame_start;
    grant_rd = rst_n && rd_elig && (!wr_valid || (level < LOW_WM_C) || !last_rd_q);
    grant_wr = rst_n && wr_valid && !grant_rd;
  end

  always_comb begin
    wr_ready  = grant_wr;
    ram_en    = grant_rd | grant_wr;
    ram_we    = grant_wr;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_wr) begin
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
    end else if (grant_rd) begin
      ram_addr  = scan_addr_q;
    end
    pix_valid = (count_q != '0);
    pix_data  = pix_valid ? fifo_mem[rd_ptr_q] : '0;
    underrun  = underrun_q;
  end

  always_comb begin
    push         = inflight_q && !frame_start;
    pop          = pix_pop && (count_q != '0) && !frame_start;
    wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d      = count_q;
    scan_addr_d  = scan_addr_q;
    frame_done_d = frame_done_q;
    underrun_d   = underrun_q;
    last_rd_d    = last_rd_q;
    inflight_d   = grant_rd;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pix_pop && (count_q == '0))
      underrun_d = 1'b1;

    // Alternation memory only moves when both sides actually competed.
    if (rd_elig && wr_valid)
      last_rd_d = grant_rd;

    if (grant_rd) begin
      if (scan_addr_q == LAST_ADDR) begin
        scan_addr_d  = '0;
        frame_done_d = 1'b1;
      end else begin
        scan_addr_d  = scan_addr_q + ADDR_W'(1);
      end
    end

    if (frame_start) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      scan_addr_d  = '0;
      frame_done_d = 1'b0;
      underrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      scan_addr_q  <= '0;
      inflight_q   <= 1'b0;
      frame_done_q <= 1'b1;
      underrun_q   <= 1'b0;
      last_rd_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      scan_addr_q  <= scan_addr_d;
      inflight_q   <= inflight_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      last_rd_q    <= last_rd_d;
    end
  end

  // Storage has no reset; the count and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_q] <= ram_rdata;
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus randomized traffic, all
// checked against a queue-based model of the FIFO, scan pointer and grant rules.
module tb_vga_fb_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int FBW    = 64;
  localparam int DEPTH  = 16;
  localparam int LOW_WM = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              pix_pop = 1'b0;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              underrun;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  int checks = 0;
  int errors = 0;

  // Model state
  int m_q[$];
  bit m_inflight;
  int m_inflight_data;
  int m_scan;
  bit m_done;
  bit m_under;
  bit m_last_r;
  bit last_rd;
  bit last_wr;

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FBW), .DEPTH(DEPTH), .LOW_WM(LOW_WM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_pop(pix_pop),
    .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Pattern RAM: a read returns its own address; writes are checked on the port only.
  always @(posedge clk) begin
    if (ram_en && !ram_we)
      ram_rdata <= 16'(ram_addr);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, 32'({pix_data, pix_valid, underrun, wr_ready, ram_en, ram_we}), 32'd0);
    chk({tag, "_ram"}, 32'({ram_addr, ram_wdata}), 32'd0);
  endtask

  function automatic int lvl();
    return m_q.size() + int'(m_inflight);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_inflight = 0;
    m_inflight_data = 0;
    m_scan = 0;
    m_done = 1;
    m_under = 0;
    m_last_r = 0;
  endtask

  task automatic drive(input bit fs, input bit pop, input bit wv,
                       input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    @(negedge clk);
    frame_start = fs;
    pix_pop = pop;
    wr_valid = wv;
    wr_addr = wa;
    wr_data = wd;
    #1;
  endtask

  // Compare DUT against the model for the current cycle, then advance the model past the edge.
  task automatic model_cycle();
    int level;
    bit rd_elig, e_rd, e_wr;
    logic [31:0] e_addr;
    level   = lvl();
    rd_elig = !m_done && (level < DEPTH) && !frame_start;
    e_rd    = rd_elig && (!wr_valid || (level < LOW_WM) || !m_last_r);
    e_wr    = wr_valid && !e_rd;
    e_addr  = e_wr ? 32'(wr_addr) : (e_rd ? 32'(m_scan) : 32'd0);
    chk("pix_valid", 32'(pix_valid), 32'(m_q.size() > 0));
    chk("pix_data", 32'(pix_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    chk("underrun", 32'(underrun), 32'(m_under));
    chk("wr_ready", 32'(wr_ready), 32'(e_wr));
    chk("ram_en", 32'(ram_en), 32'(e_rd | e_wr));
    chk("ram_we", 32'(ram_we), 32'(e_wr));
    chk("ram_addr", 32'(ram_addr), e_addr);
    chk("ram_wdata", 32'(ram_wdata), e_wr ? 32'(wr_data) : 32'd0);

    if (frame_start) begin
      m_q.delete();
      m_under = 0;
    end else begin
      if (pix_pop) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_under = 1;
      end
      if (m_inflight) m_q.push_back(m_inflight_data);
    end
    if (rd_elig && wr_valid) m_last_r = e_rd;
    m_inflight = e_rd;
    m_inflight_data = m_scan;
    if (e_rd) begin
      if (m_scan == FBW - 1) begin
        m_scan = 0;
        m_done = 1;
      end else begin
        m_scan++;
      end
    end
    if (frame_start) begin
      m_scan = 0;
      m_done = 0;
    end
    last_rd = e_rd;
    last_wr = e_wr;
  endtask

  initial begin
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    bit pend;
    bit found;
    int exp_pix;
    int pop_pct;

    // Reset with a writer already requesting: everything must read 0.
    model_reset();
    wr_valid = 1'b1;
    wr_addr = 15'h1234;
    wr_data = 16'hBEEF;
    #2;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    rst_n = 1'b1;

    // 1: lone write is granted in the same cycle
    drive(0, 0, 1, 15'h0010, 16'hF800);
    chk("t1_wr_ready", 32'(wr_ready), 32'd1);
    chk("t1_ram_we", 32'(ram_we), 32'd1);
    chk("t1_ram_addr", 32'(ram_addr), 32'h10);
    chk("t1_ram_wdata", 32'(ram_wdata), 32'hF800);
    chk("t1_pix_valid", 32'(pix_valid), 32'd0);
    model_cycle();
    drive(0, 0, 0, '0, '0);
    model_cycle();
    $display("step 1 write before first frame done");

    // 2: frame prefetch fills exactly DEPTH entries
    drive(1, 0, 0, '0, '0);
    model_cycle();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, '0, '0);
      chk("t2_rd_en", 32'(ram_en), 32'd1);
      chk("t2_rd_addr", 32'(ram_addr), 32'(i));
      model_cycle();
    end
    drive(0, 0, 0, '0, '0);
    chk("t2_idle", 32'(ram_en), 32'd0);
    chk("t2_valid", 32'(pix_valid), 32'd1);
    chk("t2_head", 32'(pix_data), 32'd0);
    model_cycle();
    $display("step 2 prefetch of %0d words", DEPTH);

    // 3: alternation above the watermark, read priority below it
    wa = 15'($urandom);
    wd = 16'($urandom);
    drive(0, 1, 1, wa, wd);
    model_cycle();
    if (last_wr) begin wa = 15'($urandom); wd = 16'($urandom); end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, wa, wd);
      chk("t3_alt_en", 32'(ram_en), 32'd1);
      chk("t3_alt_we", 32'(ram_we), 32'(k % 2));
      model_cycle();
      if (last_wr) begin wa = 15'($urandom); wd = 16'($urandom); end
    end
    for (int n = 0; n < 200 && lvl() != 3; n++) begin
      drive(0, 1, 1, wa, wd);
      model_cycle();
      if (last_wr) begin wa = 15'($urandom); wd = 16'($urandom); end
    end
    chk("t3_drain_level", 32'(lvl()), 32'd3);
    drive(0, 0, 1, wa, wd);
    chk("t3_low_rd_en", 32'(ram_en), 32'd1);
    chk("t3_low_rd_we", 32'(ram_we), 32'd0);
    model_cycle();
    drive(0, 0, 1, wa, wd);
    model_cycle();
    $display("step 3 alternation and low watermark");

    // 4: pop on an empty FIFO right after frame_start
    drive(1, 0, 0, '0, '0);
    model_cycle();
    drive(0, 1, 0, '0, '0);
    model_cycle();
    drive(0, 0, 0, '0, '0);
    chk("t4_underrun", 32'(underrun), 32'd1);
    chk("t4_black", 32'(pix_data), 32'd0);
    model_cycle();
    drive(1, 1, 0, '0, '0);
    model_cycle();
    drive(0, 0, 0, '0, '0);
    chk("t4_cleared", 32'(underrun), 32'd0);
    model_cycle();
    $display("step 4 underrun set and cleared");

    // 5: drain a whole frame in raster order, then writes own the RAM
    exp_pix = 0;
    for (int n = 0; n < 2000 && exp_pix < FBW; n++) begin
      bit p;
      p = (m_q.size() > 0);
      drive(0, p, 0, '0, '0);
      if (p) begin
        chk("t5_pix", 32'(pix_data), 32'(exp_pix));
        exp_pix++;
      end
      model_cycle();
    end
    chk("t5_count", 32'(exp_pix), 32'(FBW));
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 15'($urandom), 16'($urandom));
      chk("t5_wr_only", 32'({ram_we, wr_ready}), 32'd3);
      model_cycle();
    end
    $display("step 5 full frame of %0d pixels", FBW);

    // 6: frame_start while the read of address 20 is in flight
    drive(1, 0, 0, '0, '0);
    model_cycle();
    found = 0;
    for (int n = 0; n < 500 && !found; n++) begin
      drive(0, (m_q.size() > 0), 0, '0, '0);
      model_cycle();
      if (last_rd && m_inflight_data == 20) found = 1;
    end
    chk("t6_reached20", 32'(found), 32'd1);
    drive(1, 0, 0, '0, '0);
    model_cycle();
    drive(0, 0, 0, '0, '0);
    chk("t6_flushed", 32'(pix_valid), 32'd0);
    chk("t6_restart_addr", 32'({ram_en, ram_we, ram_addr}), 32'h10000);
    model_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, '0, '0);
      model_cycle();
    end
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr = 15'h0ABC;
    wr_data = 16'h1234;
    pix_pop = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    model_reset();
    @(negedge clk);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    $display("step 6 restart and mid-frame reset");

    // Randomized traffic
    pend = 0;
    pop_pct = 60;
    for (int c = 0; c < 3000; c++) begin
      bit fs, p;
      if (c % 100 == 0) pop_pct = int'($urandom_range(100, 20));
      fs = (c == 0) || ($urandom_range(299, 0) == 0);
      p = ($urandom_range(99, 0) < pop_pct);
      if (!pend && $urandom_range(1, 0) == 1) begin
        pend = 1;
        wa = 15'($urandom);
        wd = 16'($urandom);
      end
      drive(fs, p, pend, wa, wd);
      model_cycle();
      if (last_wr) pend = 0;
    end
    $display("step 7 randomized traffic");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
